// File: rtl/udp_app_pkg.sv
// Shared types for the UDP application controller: one-hot FSM state
// encoding and the transmit length clamp.
package udp_app_pkg;

  typedef enum logic [9:0] {
    ST_STARTUP   = 10'b00_0000_0001,
    ST_ARP_REQ   = 10'b00_0000_0010,
    ST_ARP_SEND  = 10'b00_0000_0100,
    ST_ARP_WAIT  = 10'b00_0000_1000,
    ST_READY     = 10'b00_0001_0000,
    ST_GEN_REQ   = 10'b00_0010_0000,
    ST_WRITE     = 10'b00_0100_0000,
    ST_TX_WAIT   = 10'b00_1000_0000,
    ST_CHECK_ARP = 10'b01_0000_0000,
    ST_FAIL      = 10'b10_0000_0000
  } state_t;

  function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                            input logic [15:0] max_len);
    return (len < max_len) ? len : max_len;
  endfunction

endpackage

// File: rtl/udp_rx_capture.sv
// Receive-side capture: shifts UDP payload bytes into a frame buffer and
// reports the frame length with a one-cycle pulse after valid falls.
module udp_rx_capture #(
  parameter int RX_CAPTURE_BYTES = 159
) (
  input  logic                          rgmii_clk,
  input  logic                          rstn,
  input  logic                          udp_rec_data_valid,
  input  logic [7:0]                    udp_rec_rdata,
  output logic [RX_CAPTURE_BYTES*8-1:0] rx_frame,
  output logic [15:0]                   rx_frame_len,
  output logic                          rx_frame_valid
);

  localparam int W = RX_CAPTURE_BYTES * 8;

  logic        valid_d;
  logic [15:0] byte_cnt;
  logic        frame_end;

  assign frame_end = valid_d && !udp_rec_data_valid;

  always_ff @(posedge rgmii_clk) begin
    if (!rstn) begin
      valid_d        <= 1'b0;
      byte_cnt       <= '0;
      rx_frame       <= '0;
      rx_frame_len   <= '0;
      rx_frame_valid <= 1'b0;
    end else begin
      valid_d        <= udp_rec_data_valid;
      rx_frame_valid <= frame_end;
      if (frame_end) rx_frame_len <= byte_cnt;
      if (udp_rec_data_valid) begin
        // A byte after a low-valid cycle opens a new frame and wipes older bytes.
        if (!valid_d) begin
          rx_frame <= W'(udp_rec_rdata);
          byte_cnt <= 16'd1;
        end else begin
          rx_frame <= (rx_frame << 8) | W'(udp_rec_rdata);
          byte_cnt <= (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/udp_app_ctrl.sv
// UDP application controller: ARP resolution with bounded retries, on-demand
// or periodic payload transmit into the stack, and receive capture.
module udp_app_ctrl
  import udp_app_pkg::*;
#(
  parameter int PAYLOAD_BYTES      = 120,
  parameter int RX_CAPTURE_BYTES   = 159,
  parameter int STARTUP_CYCLES     = 125_000_000,
  parameter int ARP_TIMEOUT_CYCLES = 125_000_000,
  parameter int ARP_RETRY_MAX      = 4,
  parameter int PERIOD_CYCLES      = 125_000_000
) (
  input  logic                          rgmii_clk,
  input  logic                          rstn,
  input  logic                          periodic_mode,
  input  logic                          send_req,
  input  logic [PAYLOAD_BYTES*8-1:0]    send_data,
  input  logic [15:0]                   send_len,
  output logic                          send_ready,
  output logic                          send_done,
  output logic                          arp_ok,
  output logic                          arp_fail,
  output logic                          app_data_request,
  output logic                          app_data_in_valid,
  output logic [7:0]                    app_data_in,
  output logic [15:0]                   app_data_length,
  output logic                          arp_req,
  input  logic                          udp_send_ack,
  input  logic                          arp_found,
  input  logic                          mac_not_exist,
  input  logic                          mac_send_end,
  input  logic                          udp_rec_data_valid,
  input  logic [7:0]                    udp_rec_rdata,
  output logic [RX_CAPTURE_BYTES*8-1:0] rx_frame,
  output logic [15:0]                   rx_frame_len,
  output logic                          rx_frame_valid
);

  localparam int          DW           = PAYLOAD_BYTES * 8;
  localparam logic [15:0] MAX_LEN      = 16'(PAYLOAD_BYTES);
  localparam logic [31:0] STARTUP_LAST = 32'(STARTUP_CYCLES - 1);
  localparam logic [31:0] ARP_TO_LAST  = 32'(ARP_TIMEOUT_CYCLES - 1);
  localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYCLES - 1);
  localparam logic [7:0]  RETRY_MAX    = 8'(ARP_RETRY_MAX);

  state_t          state;
  logic [31:0]     cnt;
  logic [7:0]      retry_cnt;
  logic [DW-1:0]   tx_data;
  logic [DW-1:0]   tx_shift;
  logic [15:0]     eff_len;
  logic [15:0]     byte_cnt;
  logic            have_payload;
  logic [15:0]     req_len;

  assign req_len = clamp_len(send_len, MAX_LEN);

  // NOTE: every register here is assigned with <= so all branches see the
  // pre-edge values; blocking writes would make ordering inside the case matter.
  always_ff @(posedge rgmii_clk) begin
    if (!rstn) begin
      state             <= ST_STARTUP;
      cnt               <= '0;
      retry_cnt         <= '0;
      tx_data           <= '0;
      tx_shift          <= '0;
      eff_len           <= '0;
      byte_cnt          <= '0;
      have_payload      <= 1'b0;
      send_ready        <= 1'b0;
      send_done         <= 1'b0;
      arp_ok            <= 1'b0;
      arp_fail          <= 1'b0;
      arp_req           <= 1'b0;
      app_data_request  <= 1'b0;
      app_data_in_valid <= 1'b0;
      app_data_in       <= '0;
      app_data_length   <= '0;
    end else begin
      arp_req           <= 1'b0;
      send_done         <= 1'b0;
      app_data_in_valid <= 1'b0;
      case (state)
        ST_STARTUP: begin
          if (cnt == STARTUP_LAST) begin
            state   <= ST_ARP_REQ;
            cnt     <= '0;
            arp_req <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_ARP_REQ: begin
          retry_cnt <= retry_cnt + 8'd1;
          state     <= ST_ARP_SEND;
        end
        ST_ARP_SEND: if (mac_send_end) state <= ST_ARP_WAIT;
        ST_ARP_WAIT: begin
          // A reply arriving on the timeout cycle still counts as resolved.
          if (arp_found) begin
            arp_ok     <= 1'b1;
            retry_cnt  <= '0;
            state      <= ST_READY;
            send_ready <= 1'b1;
            cnt        <= '0;
          end else if (cnt == ARP_TO_LAST) begin
            cnt <= '0;
            if (retry_cnt == RETRY_MAX) begin
              state    <= ST_FAIL;
              arp_fail <= 1'b1;
            end else begin
              state   <= ST_ARP_REQ;
              arp_req <= 1'b1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_READY: begin
          if (send_req) begin
            tx_data      <= send_data;
            eff_len      <= req_len;
            have_payload <= (req_len != 16'd0);
            if (req_len == 16'd0) begin
              send_done <= 1'b1;
              cnt       <= (cnt == PERIOD_LAST) ? '0 : cnt + 32'd1;
            end else begin
              state            <= ST_GEN_REQ;
              cnt              <= '0;
              send_ready       <= 1'b0;
              app_data_request <= 1'b1;
              app_data_length  <= req_len;
            end
          end else if (cnt == PERIOD_LAST) begin
            cnt        <= '0;
            send_ready <= 1'b0;
            if (periodic_mode && have_payload) begin
              state            <= ST_GEN_REQ;
              app_data_request <= 1'b1;
              app_data_length  <= eff_len;
            end else begin
              state <= ST_CHECK_ARP;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_GEN_REQ: begin
          if (udp_send_ack) begin
            app_data_request  <= 1'b0;
            state             <= ST_WRITE;
            app_data_in_valid <= 1'b1;
            app_data_in       <= tx_data[DW-1 -: 8];
            tx_shift          <= tx_data << 8;
            byte_cnt          <= 16'd1;
          end
        end
        ST_WRITE: begin
          if (byte_cnt == eff_len) begin
            state <= ST_TX_WAIT;
          end else begin
            app_data_in_valid <= 1'b1;
            app_data_in       <= tx_shift[DW-1 -: 8];
            tx_shift          <= tx_shift << 8;
            byte_cnt          <= byte_cnt + 16'd1;
          end
        end
        ST_TX_WAIT: begin
          if (mac_send_end) begin
            send_done <= 1'b1;
            state     <= ST_CHECK_ARP;
          end
        end
        ST_CHECK_ARP: begin
          cnt <= '0;
          if (mac_not_exist) begin
            arp_ok  <= 1'b0;
            state   <= ST_ARP_REQ;
            arp_req <= 1'b1;
          end else begin
            state      <= ST_READY;
            send_ready <= 1'b1;
          end
        end
        ST_FAIL: state <= ST_FAIL;
        default: state <= ST_STARTUP;
      endcase
    end
  end

  udp_rx_capture #(
    .RX_CAPTURE_BYTES(RX_CAPTURE_BYTES)
  ) u_rx_capture (
    .rgmii_clk         (rgmii_clk),
    .rstn              (rstn),
    .udp_rec_data_valid(udp_rec_data_valid),
    .udp_rec_rdata     (udp_rec_rdata),
    .rx_frame          (rx_frame),
    .rx_frame_len      (rx_frame_len),
    .rx_frame_valid    (rx_frame_valid)
  );

endmodule

// File: tb/tb_udp_app_ctrl.sv
// Directed bench for udp_app_ctrl with shortened timing parameters; each task
// drives one scenario and compares against hand-derived values.
module tb_udp_app_ctrl;

  localparam int PB = 4;
  localparam int RB = 4;

  logic            rgmii_clk = 1'b0;
  logic            rstn = 1'b0;
  logic            periodic_mode = 1'b0;
  logic            send_req = 1'b0;
  logic [PB*8-1:0] send_data = '0;
  logic [15:0]     send_len = '0;
  logic            send_ready, send_done, arp_ok, arp_fail;
  logic            app_data_request, app_data_in_valid, arp_req;
  logic [7:0]      app_data_in;
  logic [15:0]     app_data_length;
  logic            udp_send_ack = 1'b0, arp_found = 1'b0;
  logic            mac_not_exist = 1'b0, mac_send_end = 1'b0;
  logic            udp_rec_data_valid = 1'b0;
  logic [7:0]      udp_rec_rdata = '0;
  logic [RB*8-1:0] rx_frame;
  logic [15:0]     rx_frame_len;
  logic            rx_frame_valid;

  int vectors = 0;
  int miscompares = 0;
  int arp_req_cnt = 0;
  int req_cycles = 0;
  int done_cnt = 0;
  int rxv_cnt = 0;

  udp_app_ctrl #(
    .PAYLOAD_BYTES(PB), .RX_CAPTURE_BYTES(RB), .STARTUP_CYCLES(10),
    .ARP_TIMEOUT_CYCLES(100), .ARP_RETRY_MAX(3), .PERIOD_CYCLES(200)
  ) dut (
    .rgmii_clk(rgmii_clk), .rstn(rstn), .periodic_mode(periodic_mode),
    .send_req(send_req), .send_data(send_data), .send_len(send_len),
    .send_ready(send_ready), .send_done(send_done), .arp_ok(arp_ok),
    .arp_fail(arp_fail), .app_data_request(app_data_request),
    .app_data_in_valid(app_data_in_valid), .app_data_in(app_data_in),
    .app_data_length(app_data_length), .arp_req(arp_req),
    .udp_send_ack(udp_send_ack), .arp_found(arp_found),
    .mac_not_exist(mac_not_exist), .mac_send_end(mac_send_end),
    .udp_rec_data_valid(udp_rec_data_valid), .udp_rec_rdata(udp_rec_rdata),
    .rx_frame(rx_frame), .rx_frame_len(rx_frame_len),
    .rx_frame_valid(rx_frame_valid)
  );

  always #5 rgmii_clk = ~rgmii_clk;

  always @(posedge rgmii_clk) begin
    #2;
    if (arp_req) arp_req_cnt++;
    if (app_data_request) req_cycles++;
    if (send_done) done_cnt++;
    if (rx_frame_valid) rxv_cnt++;
  end

  task automatic step();
    @(negedge rgmii_clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0; periodic_mode = 1'b0; send_req = 1'b0; send_len = '0;
    udp_send_ack = 1'b0; arp_found = 1'b0; mac_not_exist = 1'b0;
    mac_send_end = 1'b0; udp_rec_data_valid = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
  endtask

  // Waits for an arp_req pulse, completes the send handshake, optionally replies.
  task automatic arp_exchange(input bit reply);
    int n = 0;
    while (arp_req !== 1'b1 && n < 300) begin step(); n++; end
    if (arp_req !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL arp_req_wait: no arp_req within %0d cycles", n);
    end else begin
      step(); mac_send_end = 1'b1; step(); mac_send_end = 1'b0;
      if (reply) begin
        repeat (20) step();
        arp_found = 1'b1; step(); arp_found = 1'b0;
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (send_ready !== 1'b1 && n < 400) begin step(); n++; end
    vectors++;
    if (send_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_wait: send_ready=%b after %0d cycles, expected 1", send_ready, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    rstn = 1'b0;
    vectors++;
    if ({send_ready, send_done, arp_ok, arp_fail, app_data_request,
         app_data_in_valid, arp_req, rx_frame_valid} !== 8'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {send_ready, send_done, arp_ok, arp_fail, app_data_request,
                app_data_in_valid, arp_req, rx_frame_valid});
    end
    vectors++;
    if (app_data_in !== 8'h00 || app_data_length !== 16'h0 || rx_frame !== '0 || rx_frame_len !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_data: in=%h len=%h rx=%h rxlen=%h expected all 0",
               app_data_in, app_data_length, rx_frame, rx_frame_len);
    end
    rstn = 1'b1;
    arp_req_cnt = 0;
    repeat (5) step();
    vectors++;
    if (arp_req_cnt !== 0) begin
      miscompares++;
      $display("FAIL startup_hold: arp_req pulses=%0d expected 0", arp_req_cnt);
    end
  endtask

  task automatic test_arp_retry();
    arp_exchange(1'b0);
    arp_exchange(1'b1);
    vectors++;
    if (arp_req_cnt !== 2 || arp_ok !== 1'b1 || send_ready !== 1'b1 || arp_fail !== 1'b0) begin
      miscompares++;
      $display("FAIL arp_retry: pulses=%0d ok=%b ready=%b fail=%b expected 2/1/1/0",
               arp_req_cnt, arp_ok, send_ready, arp_fail);
    end
  endtask

  task automatic test_length_clamp();
    logic [7:0] exp_b [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    wait_ready();
    send_data = 32'hA1B2C3D4; send_len = 16'd6; send_req = 1'b1;
    step(); send_req = 1'b0;
    vectors++;
    if (app_data_request !== 1'b1 || app_data_length !== 16'd4) begin
      miscompares++;
      $display("FAIL clamp_req: request=%b length=%0d expected 1/4", app_data_request, app_data_length);
    end
    step(); step();
    vectors++;
    if (app_data_request !== 1'b1 || app_data_in_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clamp_hold: request=%b valid=%b expected 1/0", app_data_request, app_data_in_valid);
    end
    udp_send_ack = 1'b1; step(); udp_send_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (app_data_in_valid !== 1'b1 || app_data_in !== exp_b[k]) begin
        miscompares++;
        $display("FAIL clamp_byte%0d: valid=%b data=%h expected 1/%h", k, app_data_in_valid, app_data_in, exp_b[k]);
      end
      step();
    end
    vectors++;
    if (app_data_in_valid !== 1'b0 || app_data_request !== 1'b0) begin
      miscompares++;
      $display("FAIL clamp_end: valid=%b request=%b expected 0/0", app_data_in_valid, app_data_request);
    end
    step(); step();
    vectors++;
    if (send_done !== 1'b0) begin
      miscompares++;
      $display("FAIL clamp_early_done: send_done=%b expected 0", send_done);
    end
    mac_send_end = 1'b1; step(); mac_send_end = 1'b0;
    vectors++;
    if (send_done !== 1'b1) begin
      miscompares++;
      $display("FAIL clamp_done: send_done=%b expected 1", send_done);
    end
    step();
    vectors++;
    if (send_done !== 1'b0 || send_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL clamp_back_ready: done=%b ready=%b expected 0/1", send_done, send_ready);
    end
  endtask

  task automatic test_zero_length();
    wait_ready();
    req_cycles = 0;
    send_len = 16'd0; send_req = 1'b1;
    step(); send_req = 1'b0;
    vectors++;
    if (send_done !== 1'b1 || send_ready !== 1'b1 || app_data_request !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len: done=%b ready=%b request=%b expected 1/1/0", send_done, send_ready, app_data_request);
    end
    repeat (5) step();
    vectors++;
    if (req_cycles !== 0 || send_done !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len_quiet: request cycles=%0d done=%b expected 0/0", req_cycles, send_done);
    end
  endtask

  task automatic test_periodic();
    int n = 0;
    wait_ready();
    periodic_mode = 1'b1;
    send_data = 32'h01020304; send_len = 16'd2; send_req = 1'b1;
    step(); send_req = 1'b0;
    udp_send_ack = 1'b1; step(); udp_send_ack = 1'b0;
    vectors++;
    if (app_data_in_valid !== 1'b1 || app_data_in !== 8'h01) begin
      miscompares++;
      $display("FAIL periodic_first: valid=%b data=%h expected 1/01", app_data_in_valid, app_data_in);
    end
    step(); step();
    mac_send_end = 1'b1; step(); mac_send_end = 1'b0;
    step();
    vectors++;
    if (send_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL periodic_ready: send_ready=%b expected 1", send_ready);
    end
    while (app_data_request !== 1'b1 && n < 400) begin step(); n++; end
    vectors++;
    if (n != 200 || app_data_length !== 16'd2) begin
      miscompares++;
      $display("FAIL periodic_interval: cycles=%0d length=%0d expected 200/2", n, app_data_length);
    end
    udp_send_ack = 1'b1; step(); udp_send_ack = 1'b0;
    step();
    vectors++;
    if (app_data_in_valid !== 1'b1 || app_data_in !== 8'h02) begin
      miscompares++;
      $display("FAIL periodic_resend: valid=%b data=%h expected 1/02", app_data_in_valid, app_data_in);
    end
    step();
    mac_send_end = 1'b1; step(); mac_send_end = 1'b0;
    mac_not_exist = 1'b1; step(); mac_not_exist = 1'b0;
    vectors++;
    if (arp_ok !== 1'b0 || arp_req !== 1'b1) begin
      miscompares++;
      $display("FAIL lost_mac: arp_ok=%b arp_req=%b expected 0/1", arp_ok, arp_req);
    end
    periodic_mode = 1'b0;
  endtask

  task automatic test_rx_capture();
    logic [7:0] frame_b [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rxv_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      udp_rec_data_valid = 1'b1; udp_rec_rdata = frame_b[k]; step();
    end
    udp_rec_data_valid = 1'b0; step();
    vectors++;
    if (rx_frame_valid !== 1'b1 || rx_frame !== 32'h22334455 || rx_frame_len !== 16'd5) begin
      miscompares++;
      $display("FAIL rx_first: valid=%b frame=%h len=%0d expected 1/22334455/5", rx_frame_valid, rx_frame, rx_frame_len);
    end
    udp_rec_data_valid = 1'b1; udp_rec_rdata = 8'h66; step();
    udp_rec_data_valid = 1'b0;
    vectors++;
    if (rx_frame_valid !== 1'b0 || rx_frame !== 32'h00000066) begin
      miscompares++;
      $display("FAIL rx_refill: valid=%b frame=%h expected 0/00000066", rx_frame_valid, rx_frame);
    end
    step();
    vectors++;
    if (rx_frame_valid !== 1'b1 || rx_frame_len !== 16'd1) begin
      miscompares++;
      $display("FAIL rx_second: valid=%b len=%0d expected 1/1", rx_frame_valid, rx_frame_len);
    end
    repeat (3) step();
    vectors++;
    if (rxv_cnt !== 2) begin
      miscompares++;
      $display("FAIL rx_pulses: pulses=%0d expected 2", rxv_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    arp_exchange(1'b1);
    wait_ready();
    send_data = 32'hDEADBEEF; send_len = 16'd4; send_req = 1'b1;
    step(); send_req = 1'b0;
    udp_send_ack = 1'b1; step(); udp_send_ack = 1'b0;
    step();
    done_cnt = 0;
    vectors++;
    if (app_data_in_valid !== 1'b1 || app_data_in !== 8'hAD) begin
      miscompares++;
      $display("FAIL midreset_pre: valid=%b data=%h expected 1/ad", app_data_in_valid, app_data_in);
    end
    rstn = 1'b0; step();
    vectors++;
    if (app_data_in_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_drop: valid=%b expected 0", app_data_in_valid);
    end
    rstn = 1'b1;
    repeat (5) step();
    vectors++;
    if (done_cnt !== 0 || arp_ok !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_quiet: done pulses=%0d arp_ok=%b expected 0/0", done_cnt, arp_ok);
    end
  endtask

  task automatic test_arp_fail();
    int n = 0;
    do_reset();
    arp_req_cnt = 0;
    repeat (3) arp_exchange(1'b0);
    while (arp_fail !== 1'b1 && n < 200) begin step(); n++; end
    vectors++;
    if (arp_fail !== 1'b1 || send_ready !== 1'b0 || arp_ok !== 1'b0) begin
      miscompares++;
      $display("FAIL arp_fail: fail=%b ready=%b ok=%b expected 1/0/0", arp_fail, send_ready, arp_ok);
    end
    repeat (150) step();
    vectors++;
    if (arp_req_cnt !== 3) begin
      miscompares++;
      $display("FAIL arp_fail_pulses: pulses=%0d expected 3", arp_req_cnt);
    end
    send_data = 32'h12345678; send_len = 16'd4; send_req = 1'b1;
    step(); send_req = 1'b0; step();
    vectors++;
    if (app_data_request !== 1'b0 || send_done !== 1'b0 || arp_fail !== 1'b1) begin
      miscompares++;
      $display("FAIL fail_ignore: request=%b done=%b fail=%b expected 0/0/1", app_data_request, send_done, arp_fail);
    end
  endtask

  initial begin
    test_reset();
    test_arp_retry();
    test_length_clamp();
    test_zero_length();
    test_periodic();
    test_rx_capture();
    test_reset_mid_frame();
    test_arp_fail();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
